fft_frame_scheduler: RTL and testbench

- Shares one fft_32 pipeline stage between NUM_CH streaming sample sources.
- Arbitrates per frame and streams exactly PERIOD samples from the winning channel into the FFT. It generates the FFT's start/over pulses and enforces an inter-frame gap.
- Tracks which channel owns each in-flight frame, so downstream logic can route FFT output.
- Sits directly upstream of fft_32 and observes its start_next output.

---
 rtl/fft_sched_pkg.sv | 17 +
 rtl/fft_sched_tag_fifo.sv | 56 +++++
 rtl/fft_frame_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_sched_pkg.sv
// Shared state type and default sizing for the FFT frame scheduler.
// Build option: FFT_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration.
package fft_sched_pkg;

    localparam int unsigned FFT_PERIOD_DEF = 32;
    localparam int unsigned NUM_CH_DEF     = 4;
    localparam int unsigned TAG_DEPTH_DEF  = 4;
    localparam int unsigned CH_W           = $clog2(NUM_CH_DEF);
    localparam int unsigned TAG_PTR_W      = $clog2(TAG_DEPTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } sched_state_e;

endpackage

// File: rtl/fft_sched_tag_fifo.sv
// Owner-tag FIFO: remembers which channel launched each frame still inside the FFT.
// Push is dropped when full and pop is dropped when empty.
module fft_sched_tag_fifo
    import fft_sched_pkg::*;
#(
    parameter int unsigned W     = CH_W,
    parameter int unsigned DEPTH = TAG_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : TAG_PTR_W;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Time-shares one fft_32 stage between NUM_CH sources, one whole frame per grant.
// Build option: FFT_SCHED_FIXED_PRIO_EN (lowest index wins) instead of round-robin.
module fft_frame_scheduler
    import fft_sched_pkg::*;
#(
    parameter int unsigned NUM_CH    = NUM_CH_DEF,
    parameter int unsigned PERIOD    = FFT_PERIOD_DEF,
    parameter int unsigned DW        = 32,
    parameter int unsigned GAP       = 2,
    parameter int unsigned TAG_DEPTH = TAG_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         ch_req,
    input  logic [NUM_CH*DW-1:0]      ch_real,
    input  logic [NUM_CH*DW-1:0]      ch_img,
    output logic [NUM_CH-1:0]         ch_rd,
    output logic                      fft_start,
    output logic                      fft_over,
    output logic [DW-1:0]             fft_real,
    output logic [DW-1:0]             fft_img,
    input  logic                      fft_start_next,
    output logic [$clog2(NUM_CH)-1:0] out_chan,
    output logic                      out_frame,
    output logic                      busy,
    output logic                      tag_err
);

    localparam int unsigned SEL_W = $clog2(NUM_CH);
    localparam int unsigned CNT_W = $clog2(PERIOD);
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    sched_state_e     state_q;
    logic [SEL_W-1:0] grant_q;
    logic [CNT_W-1:0] cnt_q;
    logic [GAP_W-1:0] gap_q;
    logic             start_q;
    logic             over_q;
    logic [DW-1:0]    real_q;
    logic [DW-1:0]    img_q;
    logic [SEL_W-1:0] chan_q;
    logic             frame_q;
    logic             err_q;
`ifndef FFT_SCHED_FIXED_PRIO_EN
    logic [SEL_W-1:0] ptr_q;
`endif

    logic [SEL_W-1:0] win_d;
    logic             win_vld_d;
    logic [DW-1:0]    smp_re;
    logic [DW-1:0]    smp_im;
    logic             last_smp;
    logic             gap_end;
    logic             arb_slot;
    logic             launch;
    logic             tag_full;
    logic             tag_empty;
    logic             tag_pop;
    logic [SEL_W-1:0] tag_head;

    always_comb begin
        win_d     = '0;
        win_vld_d = 1'b0;
`ifdef FFT_SCHED_FIXED_PRIO_EN
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (ch_req[SEL_W'(i - 1)]) begin
                win_d     = SEL_W'(i - 1);
                win_vld_d = 1'b1;
            end
        end
`else
        // Offsets scanned far-to-near so the nearest requester after the pointer is kept.
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (ch_req[SEL_W'((ptr_q + i) % NUM_CH)]) begin
                win_d     = SEL_W'((ptr_q + i) % NUM_CH);
                win_vld_d = 1'b1;
            end
        end
`endif
    end

    assign smp_re   = DW'(ch_real >> (DW * grant_q));
    assign smp_im   = DW'(ch_img >> (DW * grant_q));
    assign ch_rd    = (state_q == ST_STREAM) ? (NUM_CH'(1) << grant_q) : '0;
    assign last_smp = (state_q == ST_STREAM) && (cnt_q == CNT_W'(PERIOD - 1));
    assign gap_end  = (state_q == ST_GAP) && (gap_q == GAP_W'(GAP - 1));

    // Arbitrating in the last GAP (or, with GAP=0, last STREAM) cycle keeps exactly
    // GAP idle ch_rd cycles between frames instead of GAP plus an IDLE cycle.
    assign arb_slot = (state_q == ST_IDLE) || gap_end || ((GAP == 0) && last_smp);
    assign launch   = arb_slot && win_vld_d && !tag_full;
    assign tag_pop  = fft_start_next && !tag_empty;

    fft_sched_tag_fifo #(
        .W     (SEL_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (launch),
        .push_data_i (win_d),
        .pop_i       (fft_start_next),
        .head_o      (tag_head),
        .full_o      (tag_full),
        .empty_o     (tag_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            start_q <= 1'b0;
            over_q  <= 1'b0;
            real_q  <= '0;
            img_q   <= '0;
            chan_q  <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            start_q <= (state_q == ST_STREAM) && (cnt_q == '0);
            over_q  <= last_smp;
            real_q  <= (state_q == ST_STREAM) ? smp_re : '0;
            img_q   <= (state_q == ST_STREAM) ? smp_im : '0;
            frame_q <= tag_pop;
            if (tag_pop) begin
                chan_q <= tag_head;
            end
            if (fft_start_next && tag_empty) begin
                err_q <= 1'b1;
            end
            if (launch) begin
                grant_q <= win_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        state_q <= ST_STREAM;
                        cnt_q   <= '0;
                    end
                end
                ST_STREAM: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (last_smp) begin
                        cnt_q <= '0;
                        if (GAP != 0) begin
                            state_q <= ST_GAP;
                            gap_q   <= '0;
                        end else begin
                            state_q <= launch ? ST_STREAM : ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    gap_q <= gap_q + 1'b1;
                    if (gap_end) begin
                        state_q <= launch ? ST_STREAM : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifndef FFT_SCHED_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= SEL_W'(NUM_CH - 1);
        end else if (launch) begin
            ptr_q <= win_d;
        end
    end
`endif

    assign fft_start = start_q;
    assign fft_over  = over_q;
    assign fft_real  = real_q;
    assign fft_img   = img_q;
    assign out_chan  = chan_q;
    assign out_frame = frame_q;
    assign tag_err   = err_q;
    assign busy      = (state_q != ST_IDLE) || !tag_empty;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Scoreboard bench: a frame-level reference model predicts launches, samples and tags.
module tb_fft_frame_scheduler;

    localparam int NUM_CH    = 4;
    localparam int PERIOD    = 32;
    localparam int DW        = 32;
    localparam int GAP       = 2;
    localparam int TAG_DEPTH = 4;
    localparam int SW        = $clog2(NUM_CH);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH*DW-1:0] ch_real;
    logic [NUM_CH*DW-1:0] ch_img;
    logic [NUM_CH-1:0]    ch_rd;
    logic                 fft_start;
    logic                 fft_over;
    logic [DW-1:0]        fft_real;
    logic [DW-1:0]        fft_img;
    logic                 fft_start_next;
    logic [SW-1:0]        out_chan;
    logic                 out_frame;
    logic                 busy;
    logic                 tag_err;

    always #5 clk = ~clk;

    fft_frame_scheduler #(
        .NUM_CH    (NUM_CH),
        .PERIOD    (PERIOD),
        .DW        (DW),
        .GAP       (GAP),
        .TAG_DEPTH (TAG_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ch_req         (ch_req),
        .ch_real        (ch_real),
        .ch_img         (ch_img),
        .ch_rd          (ch_rd),
        .fft_start      (fft_start),
        .fft_over       (fft_over),
        .fft_real       (fft_real),
        .fft_img        (fft_img),
        .fft_start_next (fft_start_next),
        .out_chan       (out_chan),
        .out_frame      (out_frame),
        .busy           (busy),
        .tag_err        (tag_err)
    );

    typedef struct { int launch; int chan; int first; } frame_t;
    typedef struct { int cyc; int chan; } tag_t;

    frame_t      exp_q[$];
    tag_t        out_q[$];
    int          tags[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;
    int          src_idx[NUM_CH];
    int          m_idx[NUM_CH];
    int          arb_ok = 0;
    int          busy_until = -1;
    int          m_ptr = NUM_CH - 1;
    bit          m_err = 1'b0;
    int          m_out_chan = 0;
    frame_t      cur;
    bit          cur_v = 1'b0;
    int          rd_to = -1;
    bit          mon_act = 1'b0;
    int          mon_n = 0;
    frame_t      mon_f;
    logic [NUM_CH-1:0] rd_seen = '0;

    function automatic logic [DW-1:0] smp_re(input int ch, input int idx);
        return DW'(ch * 32'h0100_0000 + idx * 32'h0001_9E37) ^ 32'h1234_5678;
    endfunction

    function automatic logic [DW-1:0] smp_im(input int ch, input int idx);
        return DW'(idx * 7 + ch * 32'h0011_0000) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic int pick(input logic [NUM_CH-1:0] r, input int ptr);
        logic [NUM_CH-1:0] m;
`ifdef FFT_SCHED_FIXED_PRIO_EN
        for (int k = 0; k < NUM_CH; k++) begin
            m = r >> k;
            if (m[0]) return k;
        end
`else
        for (int k = 1; k <= NUM_CH; k++) begin
            m = r >> ((ptr + k) % NUM_CH);
            if (m[0]) return (ptr + k) % NUM_CH;
        end
`endif
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Sources: each channel presents its next sample and advances on every observed pop.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_seen[i]) src_idx[i]++;
            ch_real[i*DW +: DW] = smp_re(i, src_idx[i]);
            ch_img[i*DW +: DW]  = smp_im(i, src_idx[i]);
        end
    end

    always @(negedge clk) begin : monitor_and_model
        logic [NUM_CH-1:0] e_rd;
        tag_t   t;
        bit     was_full;
        int     w;
        if (chk_en) begin
            e_rd = '0;
            if (cur_v && cyc > cur.launch && cyc <= rd_to) e_rd = NUM_CH'(1) << cur.chan;
            chk("ch_rd", 64'(ch_rd), 64'(e_rd));
            chk("busy", 64'(busy), 64'((cyc <= busy_until) || (tags.size() > 0)));
            chk("tag_err", 64'(tag_err), 64'(m_err));
            chk("out_chan", 64'(out_chan), 64'(m_out_chan));

            if (fft_start && !mon_act) begin
                if (exp_q.size() == 0) begin
                    chk("start_unexpected", 64'(fft_start), 64'd0);
                end else begin
                    mon_f   = exp_q.pop_front();
                    chk("start_cycle", 64'(cyc), 64'(mon_f.launch + 2));
                    mon_act = 1'b1;
                    mon_n   = 0;
                end
            end
            if (mon_act) begin
                chk("fft_real", 64'(fft_real), 64'(smp_re(mon_f.chan, mon_f.first + mon_n)));
                chk("fft_img", 64'(fft_img), 64'(smp_im(mon_f.chan, mon_f.first + mon_n)));
                chk("fft_start", 64'(fft_start), 64'(mon_n == 0));
                chk("fft_over", 64'(fft_over), 64'(mon_n == PERIOD - 1));
                mon_n++;
                if (mon_n == PERIOD) mon_act = 1'b0;
            end else begin
                chk("idle_data", {fft_real, fft_img}, 64'd0);
                chk("idle_flags", 64'({fft_start, fft_over}), 64'd0);
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].launch + 2) begin
                chk("start_timeout", 64'(cyc), 64'(exp_q[0].launch + 2));
                void'(exp_q.pop_front());
            end

            if (out_frame) begin
                if (out_q.size() == 0) begin
                    chk("out_frame_unexpected", 64'(out_frame), 64'd0);
                end else begin
                    t = out_q.pop_front();
                    chk("out_frame_cycle", 64'(cyc), 64'(t.cyc));
                    chk("out_frame_chan", 64'(out_chan), 64'(t.chan));
                end
            end
            if (out_q.size() > 0 && cyc > out_q[0].cyc) begin
                chk("out_frame_timeout", 64'(cyc), 64'(out_q[0].cyc));
                void'(out_q.pop_front());
            end
        end

        // Frame-level reference: a launch reserves PERIOD+GAP cycles before the next one.
        if (rst) begin
            if (cur_v && cyc <= rd_to) m_idx[cur.chan] = cur.first + (cyc - cur.launch);
            if (cyc < rd_to) rd_to = cyc;
            exp_q.delete();
            out_q.delete();
            tags.delete();
            mon_act    = 1'b0;
            arb_ok     = cyc + 1;
            busy_until = -1;
            m_ptr      = NUM_CH - 1;
            m_err      = 1'b0;
            m_out_chan = 0;
        end else begin
            was_full = (tags.size() == TAG_DEPTH);
            if (fft_start_next) begin
                if (tags.size() > 0) begin
                    m_out_chan = tags.pop_front();
                    out_q.push_back('{cyc + 1, m_out_chan});
                end else begin
                    m_err = 1'b1;
                end
            end
            if (cyc >= arb_ok && ch_req != '0 && !was_full) begin
                w     = pick(ch_req, m_ptr);
                m_ptr = w;
                tags.push_back(w);
                cur   = '{cyc, w, m_idx[w]};
                cur_v = 1'b1;
                exp_q.push_back(cur);
                rd_to      = cyc + PERIOD;
                m_idx[w]   = m_idx[w] + PERIOD;
                arb_ok     = cyc + PERIOD + GAP;
                busy_until = cyc + PERIOD + GAP;
            end
        end
        rd_seen = ch_rd;
    end

    task automatic step(input logic [NUM_CH-1:0] r, input logic p, input logic rs);
        ch_req         = r;
        fft_start_next = p;
        rst            = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NUM_CH-1:0] rq;
        rst            = 1'b1;
        ch_req         = '0;
        fft_start_next = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            src_idx[i] = 0;
            m_idx[i]   = 0;
            ch_real[i*DW +: DW] = smp_re(i, 0);
            ch_img[i*DW +: DW]  = smp_im(i, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        repeat (4) step(4'h0, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        repeat (40) step(4'h0, 1'b0, 1'b0);
        step(4'h0, 1'b1, 1'b0);
        repeat (3) step(4'h0, 1'b0, 1'b0);
        step(4'h0, 1'b1, 1'b0);
        repeat (3) step(4'h0, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b1);
        repeat (2) step(4'h0, 1'b0, 1'b0);

        repeat (200) step(4'hF, 1'b0, 1'b0);
        step(4'hF, 1'b1, 1'b0);
        repeat (40) step(4'hF, 1'b0, 1'b0);
        repeat (6) begin
            step(4'h0, 1'b1, 1'b0);
            repeat (5) step(4'h0, 1'b0, 1'b0);
        end

        step(4'h0, 1'b0, 1'b1);
        step(4'h0, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        repeat (35) step(4'h0, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        repeat (40) step(4'h0, 1'b0, 1'b0);
        step(4'h0, 1'b1, 1'b0);
        step(4'h0, 1'b0, 1'b0);
        step(4'h0, 1'b1, 1'b0);
        repeat (3) step(4'h0, 1'b0, 1'b0);

        step(4'b0110, 1'b0, 1'b0);
        repeat (16) step(4'h0, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b1);
        step(4'hF, 1'b0, 1'b0);
        repeat (40) step(4'h0, 1'b0, 1'b0);

        rq = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rq = NUM_CH'($urandom);
            step(rq, $urandom_range(0, 24) == 0, $urandom_range(0, 999) == 0);
        end
        repeat (5) step(4'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
